crop: RTL and testbench
=======================

CROP -- requirements
Module: crop

Interface
REQ-001 Parameter IMG_WIDTH, default 8, SHALL set bits per channel sample.
REQ-002 Parameter CHANNELS, default 1, SHALL set samples packed per pixel, channel 0 in LSBs.
REQ-003 Parameter COL_AWIDTH, default 12, SHALL set width of column config/counter.
REQ-004 Parameter ROW_AWIDTH, default 12, SHALL set width of row config/counter.
REQ-005 clk  input  1  SHALL be the clock; all logic on posedge.
REQ-006 rst  input  1  SHALL be reset, synchronous, active-high.
REQ-007 cfg_row_len  input  COL_AWIDTH  SHALL give input pixels per row.
REQ-008 cfg_col_start / cfg_col_end  input  COL_AWIDTH each  SHALL give first/last kept column, inclusive.
REQ-009 cfg_rows  input  ROW_AWIDTH  SHALL give input rows per frame.
REQ-010 cfg_row_start / cfg_row_end  input  ROW_AWIDTH each  SHALL give first/last kept row, inclusive.
REQ-011 cfg_set  input  1  SHALL load all cfg_* inputs when high for one cycle.
REQ-012 cfg_err  output  1  SHALL flag the last loaded config as invalid.
REQ-013 up_data  input  CHANNELS*IMG_WIDTH, up_val  input  1, up_rdy  output  1  SHALL form the upstream valid/ready stream.
REQ-014 dn_data  output  CHANNELS*IMG_WIDTH, dn_val  output  1, dn_rdy  input  1  SHALL form the downstream valid/ready stream.
REQ-015 dn_eol / dn_eof  output  1 each  SHALL mark last kept pixel of a row / of a frame, qualified by dn_val.

Function
REQ-016 Block SHALL have states IDLE and RUN; rst enters IDLE.
REQ-017 In IDLE, up_rdy SHALL be 0 and dn_val SHALL be 0.
REQ-018 cfg_set SHALL register config the same edge; next cycle state SHALL be RUN with counters zeroed if config valid, else IDLE with cfg_err=1.
REQ-019 Config SHALL be valid iff row_len!=0, rows!=0, col_start<=col_end<row_len, row_start<=row_end<rows (unsigned compares).
REQ-020 cfg_set in RUN SHALL clear dn_val and counters, drop in-flight pixel, and force up_rdy=0 in the cfg_set cycle.
REQ-021 Transfer SHALL occur on up_val&up_rdy; up_rdy in RUN SHALL equal dn_rdy | ~dn_val (single output register, no combinational up_val->dn_val path).
REQ-022 Each transfer SHALL advance col_cnt; at col_cnt==row_len-1 col_cnt SHALL wrap to 0 and row_cnt advance; at row_cnt==rows-1 with column wrap row_cnt SHALL wrap to 0.
REQ-023 Pixel SHALL be kept iff col_start<=col_cnt<=col_end and row_start<=row_cnt<=row_end; dropped pixels SHALL be consumed with no output.
REQ-024 Kept pixel SHALL appear on dn_data/dn_val the cycle after transfer (latency 1) and hold, unmodified, until dn_val&dn_rdy.
REQ-025 dn_eol SHALL be 1 with pixel at col_end; dn_eof SHALL be 1 with pixel at col_end and row_end.
REQ-026 Counter arithmetic SHALL be modulo 2^width; no counter SHALL exceed its configured limit.
REQ-027 Output register consumed and new pixel transferred in the same cycle SHALL load the new pixel with no bubble.

Reset
REQ-028 rst SHALL set state=IDLE, dn_val=0, dn_eol=0, dn_eof=0, cfg_err=0, up_rdy=0, counters=0; rst overrides cfg_set.
REQ-029 dn_data and config registers SHALL need no reset; rst mid-frame SHALL discard in-flight pixel and require new cfg_set.

Verification
REQ-030 row_len=8, cols 2..5, rows=2, rows 0..1, dn_rdy=1, 16 pixels 0..15 -> out 2,3,4,5,10,11,12,13; eol on 5,13; eof on 13.
REQ-031 Same config, dn_rdy random 50% -> identical output sequence, dn_data stable while dn_val&~dn_rdy.
REQ-032 rows=4, rows 1..2, row_len=4, cols 0..3, 16 pixels -> out 4..11, eof on 11, then next frame repeats pattern.
REQ-033 col_end=8 with row_len=8 -> cfg_err=1, up_rdy stays 0; then valid cfg_set -> cfg_err=0, RUN.
REQ-034 cfg_set after 3 pixels of a row -> held pixel dropped, next pixel counted as col 0 row 0.
REQ-035 rst asserted mid-frame with dn_val=1 -> next cycle dn_val=0, up_rdy=0, IDLE.

Source files
------------

// File: rtl/crop.sv
// ---------------------------------------------------------------------------
// crop
//
// Crops a rectangular window out of a raster-scanned pixel stream. Every
// upstream pixel is consumed. Pixels inside the configured column and row
// window are forwarded downstream. Pixels outside the window are dropped
// silently. The block has one output register, so a kept pixel appears one
// cycle after its transfer. Upstream ready is derived only from the state of
// that register, which keeps up_val from reaching dn_val combinationally.
//
// Parameters
//   IMG_WIDTH   bits per channel sample
//   CHANNELS    samples packed per pixel, channel 0 in the LSBs
//   COL_AWIDTH  width of the column configuration and column counter
//   ROW_AWIDTH  width of the row configuration and row counter
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous, active-high reset
//   cfg_row_len    input pixels per row
//   cfg_col_start  first kept column (inclusive)
//   cfg_col_end    last kept column (inclusive)
//   cfg_rows       input rows per frame
//   cfg_row_start  first kept row (inclusive)
//   cfg_row_end    last kept row (inclusive)
//   cfg_set        one-cycle strobe that loads every cfg_* input
//   cfg_err        high when the last loaded configuration was invalid
//   up_data        upstream pixel
//   up_val         upstream valid
//   up_rdy         upstream ready
//   dn_data        downstream pixel
//   dn_val         downstream valid
//   dn_rdy         downstream ready
//   dn_eol         last kept pixel of a row, qualified by dn_val
//   dn_eof         last kept pixel of a frame, qualified by dn_val
// ---------------------------------------------------------------------------
module crop #(
    parameter int IMG_WIDTH  = 8,
    parameter int CHANNELS   = 1,
    parameter int COL_AWIDTH = 12,
    parameter int ROW_AWIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [COL_AWIDTH-1:0]         cfg_row_len,
    input  logic [COL_AWIDTH-1:0]         cfg_col_start,
    input  logic [COL_AWIDTH-1:0]         cfg_col_end,
    input  logic [ROW_AWIDTH-1:0]         cfg_rows,
    input  logic [ROW_AWIDTH-1:0]         cfg_row_start,
    input  logic [ROW_AWIDTH-1:0]         cfg_row_end,
    input  logic                          cfg_set,
    output logic                          cfg_err,

    input  logic [CHANNELS*IMG_WIDTH-1:0] up_data,
    input  logic                          up_val,
    output logic                          up_rdy,

    output logic [CHANNELS*IMG_WIDTH-1:0] dn_data,
    output logic                          dn_val,
    input  logic                          dn_rdy,
    output logic                          dn_eol,
    output logic                          dn_eof
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   cfg_err_next;

    // Registered configuration
    logic [COL_AWIDTH-1:0] row_len_r;
    logic [COL_AWIDTH-1:0] col_start_r;
    logic [COL_AWIDTH-1:0] col_end_r;
    logic [ROW_AWIDTH-1:0] rows_r;
    logic [ROW_AWIDTH-1:0] row_start_r;
    logic [ROW_AWIDTH-1:0] row_end_r;

    // Raster position of the pixel currently offered upstream
    logic [COL_AWIDTH-1:0] col_cnt;
    logic [ROW_AWIDTH-1:0] row_cnt;

    logic cfg_valid;
    logic xfer;
    logic keep;
    logic last_col;
    logic last_row;
    logic at_col_end;
    logic at_row_end;

    // The validity check looks at the incoming cfg_* values, not the
    // registered copies, so the state decision is made on the same edge
    // that loads the configuration.
    assign cfg_valid = (cfg_row_len != '0) &&
                       (cfg_rows != '0) &&
                       (cfg_col_start <= cfg_col_end) &&
                       (cfg_col_end < cfg_row_len) &&
                       (cfg_row_start <= cfg_row_end) &&
                       (cfg_row_end < cfg_rows);

    // Ready depends only on the output register being free or draining.
    // It is held low during a cfg_set cycle or a reset cycle so that no
    // pixel can slip in while the counters are being cleared.
    assign up_rdy = (state == RUN) && !cfg_set && !rst && (dn_rdy || !dn_val);
    assign xfer   = up_val && up_rdy;

    assign last_col   = (col_cnt == (row_len_r - COL_AWIDTH'(1)));
    assign last_row   = (row_cnt == (rows_r - ROW_AWIDTH'(1)));
    assign at_col_end = (col_cnt == col_end_r);
    assign at_row_end = (row_cnt == row_end_r);

    assign keep = (col_cnt >= col_start_r) && (col_cnt <= col_end_r) &&
                  (row_cnt >= row_start_r) && (row_cnt <= row_end_r);

    // State register. Reset returns to IDLE and clears the error flag.
    // Reset takes priority over cfg_set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            cfg_err <= cfg_err_next;
        end
    end

    // Next-state logic. A cfg_set in either state restarts the block.
    // A valid configuration goes to RUN. An invalid one parks in IDLE with
    // the error flag raised until a later load succeeds.
    always_comb begin
        state_next   = state;
        cfg_err_next = cfg_err;
        if (cfg_set) begin
            if (cfg_valid) begin
                state_next   = RUN;
                cfg_err_next = 1'b0;
            end else begin
                state_next   = IDLE;
                cfg_err_next = 1'b1;
            end
        end
    end

    // Configuration capture. These registers have no reset. Their contents
    // only matter in RUN, and RUN is reachable only through a cfg_set.
    always_ff @(posedge clk) begin
        if (cfg_set && !rst) begin
            row_len_r   <= cfg_row_len;
            col_start_r <= cfg_col_start;
            col_end_r   <= cfg_col_end;
            rows_r      <= cfg_rows;
            row_start_r <= cfg_row_start;
            row_end_r   <= cfg_row_end;
        end
    end

    // Raster counters. The column counter wraps at the end of each row.
    // The row counter steps on that wrap and wraps itself on the last row,
    // so the next frame starts again at column 0, row 0.
    always_ff @(posedge clk) begin
        if (rst || cfg_set) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (xfer) begin
            if (last_col) begin
                col_cnt <= '0;
                if (last_row) begin
                    row_cnt <= '0;
                end else begin
                    row_cnt <= row_cnt + ROW_AWIDTH'(1);
                end
            end else begin
                col_cnt <= col_cnt + COL_AWIDTH'(1);
            end
        end
    end

    // Output valid and markers. A transfer is only possible when the
    // register is empty or being consumed on this edge. The transfer result
    // therefore overwrites the register directly, with no bubble. A dropped
    // pixel simply leaves the register empty.
    always_ff @(posedge clk) begin
        if (rst || cfg_set) begin
            dn_val <= 1'b0;
            dn_eol <= 1'b0;
            dn_eof <= 1'b0;
        end else if (xfer) begin
            dn_val <= keep;
            dn_eol <= keep && at_col_end;
            dn_eof <= keep && at_col_end && at_row_end;
        end else if (dn_rdy) begin
            dn_val <= 1'b0;
            dn_eol <= 1'b0;
            dn_eof <= 1'b0;
        end
    end

    // Output data has no reset. It is only loaded by a kept transfer and is
    // ignored whenever dn_val is low.
    always_ff @(posedge clk) begin
        if (xfer && keep) begin
            dn_data <= up_data;
        end
    end

endmodule

// File: tb/tb_crop.sv
// ---------------------------------------------------------------------------
// tb_crop
//
// Self-checking bench for crop, scoreboard style. Stimulus tasks push the
// hand-computed expected pixel, eol and eof into a queue. A separate monitor
// pops the queue on every downstream handshake. The monitor also checks that
// a stalled output holds its data.
// ---------------------------------------------------------------------------
module tb_crop;

    localparam int IW = 8;
    localparam int CH = 1;
    localparam int CW = 12;
    localparam int RW = 12;

    logic            clk;
    logic            rst;
    logic [CW-1:0]   cfg_row_len;
    logic [CW-1:0]   cfg_col_start;
    logic [CW-1:0]   cfg_col_end;
    logic [RW-1:0]   cfg_rows;
    logic [RW-1:0]   cfg_row_start;
    logic [RW-1:0]   cfg_row_end;
    logic            cfg_set;
    logic            cfg_err;
    logic [CH*IW-1:0] up_data;
    logic            up_val;
    logic            up_rdy;
    logic [CH*IW-1:0] dn_data;
    logic            dn_val;
    logic            dn_rdy;
    logic            dn_eol;
    logic            dn_eof;

    typedef struct packed {
        logic [7:0] data;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    logic rdyFixed  = 1'b1;
    bit   rdyRandom = 1'b0;

    crop #(
        .IMG_WIDTH (IW),
        .CHANNELS  (CH),
        .COL_AWIDTH(CW),
        .ROW_AWIDTH(RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_row_len  (cfg_row_len),
        .cfg_col_start(cfg_col_start),
        .cfg_col_end  (cfg_col_end),
        .cfg_rows     (cfg_rows),
        .cfg_row_start(cfg_row_start),
        .cfg_row_end  (cfg_row_end),
        .cfg_set      (cfg_set),
        .cfg_err      (cfg_err),
        .up_data      (up_data),
        .up_val       (up_val),
        .up_rdy       (up_rdy),
        .dn_data      (dn_data),
        .dn_val       (dn_val),
        .dn_rdy       (dn_rdy),
        .dn_eol       (dn_eol),
        .dn_eof       (dn_eof)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectPixel(input logic [7:0] d, input logic eol, input logic eof);
        exp_t e;
        e.data = d;
        e.eol  = eol;
        e.eof  = eof;
        expQ.push_back(e);
    endtask

    // Loads a configuration with a one-cycle cfg_set pulse.
    // Entered and left at posedge+1.
    task automatic configure(input int rowLen, input int colStart, input int colEnd,
                             input int rows, input int rowStart, input int rowEnd);
        cfg_row_len   = CW'(rowLen);
        cfg_col_start = CW'(colStart);
        cfg_col_end   = CW'(colEnd);
        cfg_rows      = RW'(rows);
        cfg_row_start = RW'(rowStart);
        cfg_row_end   = RW'(rowEnd);
        cfg_set       = 1'b1;
        @(posedge clk); #1;
        cfg_set       = 1'b0;
    endtask

    // Offers one pixel upstream and waits, within a bounded time, for it to
    // be accepted
    task automatic applyStimulus(input logic [7:0] d);
        bit got;
        got     = 1'b0;
        up_data = d;
        up_val  = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (up_rdy) got = 1'b1;
            @(posedge clk); #1;
        end
        up_val = 1'b0;
        checkOutput("upstream_handshake", 32'(got), 32'd1);
    endtask

    // Waits, within a bounded time, until every expected pixel has been seen
    task automatic waitDrain();
        for (int i = 0; i < 300 && expQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Downstream ready: either a fixed level or a coin flip every cycle
    initial begin
        dn_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            dn_rdy = rdyRandom ? 1'($urandom_range(0, 1)) : rdyFixed;
        end
    end

    // Monitor. It samples on the falling edge, so the values seen here are
    // the ones the next rising edge will act on. A handshake pops the
    // scoreboard. A stall records the data, which must still be there one
    // cycle later unless a reset or cfg_set intervenes.
    initial begin
        exp_t       e;
        bit         prevHold;
        logic [7:0] prevData;
        prevHold = 1'b0;
        prevData = '0;
        forever begin
            @(negedge clk);
            if (prevHold) begin
                checkOutput("stall_dn_val", 32'(dn_val), 32'd1);
                checkOutput("stall_dn_data", 32'(dn_data), 32'(prevData));
            end
            if (dn_val && dn_rdy && !rst && !cfg_set) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=0x%0h expected=none", dn_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("dn_data", 32'(dn_data), 32'(e.data));
                    checkOutput("dn_eol", 32'(dn_eol), 32'(e.eol));
                    checkOutput("dn_eof", 32'(dn_eof), 32'(e.eof));
                end
            end
            prevHold = dn_val && !dn_rdy && !rst && !cfg_set;
            prevData = dn_data;
        end
    end

    // Watchdog, in case something stalls outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        rst           = 1'b1;
        cfg_set       = 1'b0;
        cfg_row_len   = '0;
        cfg_col_start = '0;
        cfg_col_end   = '0;
        cfg_rows      = '0;
        cfg_row_start = '0;
        cfg_row_end   = '0;
        up_data       = '0;
        up_val        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_up_rdy", 32'(up_rdy), 32'd0);
        checkOutput("reset_dn_val", 32'(dn_val), 32'd0);
        checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("reset_dn_eol", 32'(dn_eol), 32'd0);
        checkOutput("reset_dn_eof", 32'(dn_eof), 32'd0);
        @(posedge clk); #1;

        // Columns 2..5 of an 8x2 frame, downstream always ready
        $display("[TB] basic column crop");
        configure(8, 2, 5, 2, 0, 1);
        expectPixel(8'd2, 0, 0);  expectPixel(8'd3, 0, 0);
        expectPixel(8'd4, 0, 0);  expectPixel(8'd5, 1, 0);
        expectPixel(8'd10, 0, 0); expectPixel(8'd11, 0, 0);
        expectPixel(8'd12, 0, 0); expectPixel(8'd13, 1, 1);
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        waitDrain();

        // Same crop with downstream ready toggling randomly
        $display("[TB] backpressure");
        configure(8, 2, 5, 2, 0, 1);
        rdyRandom = 1'b1;
        expectPixel(8'd2, 0, 0);  expectPixel(8'd3, 0, 0);
        expectPixel(8'd4, 0, 0);  expectPixel(8'd5, 1, 0);
        expectPixel(8'd10, 0, 0); expectPixel(8'd11, 0, 0);
        expectPixel(8'd12, 0, 0); expectPixel(8'd13, 1, 1);
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        waitDrain();
        rdyRandom = 1'b0;
        idleCycles(2);

        // Rows 1..2 of a 4x4 frame, full width, over two frames
        $display("[TB] row crop over two frames");
        configure(4, 0, 3, 4, 1, 2);
        for (int f = 0; f < 2; f++) begin
            for (int p = 4; p < 12; p++) begin
                expectPixel(8'(f * 16 + p), (p % 4) == 3, p == 11);
            end
        end
        for (int i = 0; i < 32; i++) applyStimulus(8'(i));
        waitDrain();

        // Invalid config: col_end equal to row_len
        $display("[TB] invalid configuration");
        configure(8, 2, 8, 2, 0, 1);
        @(negedge clk);
        checkOutput("bad_cfg_err", 32'(cfg_err), 32'd1);
        checkOutput("bad_cfg_up_rdy", 32'(up_rdy), 32'd0);
        @(posedge clk); #1;
        up_data = 8'hEE;
        up_val  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bad_cfg_up_rdy_hold", 32'(up_rdy), 32'd0);
            checkOutput("bad_cfg_dn_val", 32'(dn_val), 32'd0);
            @(posedge clk); #1;
        end
        up_val = 1'b0;
        configure(8, 2, 5, 2, 0, 1);
        @(negedge clk);
        checkOutput("good_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("good_cfg_up_rdy", 32'(up_rdy), 32'd1);
        @(posedge clk); #1;

        // cfg_set while a pixel is held. The held pixel is dropped and the
        // counters restart at column 0, row 0.
        $display("[TB] reconfigure mid-row");
        configure(4, 0, 3, 2, 0, 0);
        expectPixel(8'hA0, 0, 0);
        expectPixel(8'hA1, 0, 0);
        applyStimulus(8'hA0);
        applyStimulus(8'hA1);
        waitDrain();
        rdyFixed = 1'b0;
        idleCycles(2);
        applyStimulus(8'hA2);
        @(negedge clk);
        checkOutput("held_dn_val", 32'(dn_val), 32'd1);
        checkOutput("held_dn_data", 32'(dn_data), 32'hA2);
        @(posedge clk); #1;
        configure(4, 0, 3, 2, 0, 0);
        @(negedge clk);
        checkOutput("reconfig_dn_val", 32'(dn_val), 32'd0);
        @(posedge clk); #1;
        rdyFixed = 1'b1;
        idleCycles(2);
        expectPixel(8'hB0, 0, 0); expectPixel(8'hB1, 0, 0);
        expectPixel(8'hB2, 0, 0); expectPixel(8'hB3, 1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'hB0 + i));
        waitDrain();

        // Reset with a pixel waiting at the output
        $display("[TB] reset mid-frame");
        configure(4, 0, 3, 1, 0, 0);
        rdyFixed = 1'b0;
        idleCycles(2);
        applyStimulus(8'h5A);
        @(negedge clk);
        checkOutput("pre_reset_dn_val", 32'(dn_val), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_dn_val", 32'(dn_val), 32'd0);
        checkOutput("post_reset_up_rdy", 32'(up_rdy), 32'd0);
        checkOutput("post_reset_dn_eol", 32'(dn_eol), 32'd0);
        checkOutput("post_reset_dn_eof", 32'(dn_eof), 32'd0);
        @(posedge clk); #1;
        rdyFixed = 1'b1;
        up_data  = 8'h77;
        up_val   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_idle_up_rdy", 32'(up_rdy), 32'd0);
            checkOutput("post_reset_idle_dn_val", 32'(dn_val), 32'd0);
            @(posedge clk); #1;
        end
        up_val = 1'b0;
        idleCycles(2);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
